maze_mem: RTL and testbench
===========================

Name: maze_mem

Overview:
- Cell store that sits directly under the maze solver and answers its row/col read (maze_oe) and mark (maze_we) requests.
- Before a solve, it loads a 2^maze_width x 2^maze_width wall bitmap over a valid/ready stream.
- After the solver asserts done, it streams the visited-cell map out, one cell at a time.
- It is the memory stage between the maze loader/testbench and the solver, and between the solver and the result consumer.

Parameters:
- maze_width, 6, bits per row/col index; grid is N x N with N = 2^maze_width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin bitmap load (accepted in IDLE or DONE only)
- load_valid  in  1  load_data valid
- load_data  in  1  wall bit for current load cell (1 = wall)
- load_ready  out  1  block accepts load_data this cycle
- mem_ready  out  1  maze loaded, serving solver
- row  in  maze_width  solver row index
- col  in  maze_width  solver col index
- maze_oe  in  1  solver read enable, synchronous
- maze_we  in  1  solver mark-visited enable, synchronous
- maze_in  out  1  wall bit of cell read (registered)
- solver_done  in  1  solver finished (level)
- out_valid  out  1  dump cell valid
- out_ready  in  1  consumer accepts dump cell
- out_row  out  maze_width  dump cell row
- out_col  out  maze_width  dump cell col
- out_visited  out  1  dump cell marked by solver
- dump_done  out  1  dump complete (level, until next load)
- wall_hit  out  1  sticky: solver marked a wall cell

Behaviour:
- Storage: 2 bits per cell (wall, visited); address = {row, col}, row-major.
- Reset (async, rst_n=0): state IDLE. All outputs 0 except maze_in=1. Internal counters 0. Memory contents not cleared.
- States: IDLE, LOAD, SERVE, DUMP, DONE.
- IDLE / DONE: load_start=1 -> LOAD with load counter = 0. Other inputs ignored. In DONE, dump_done=1.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid&&load_ready writes wall=load_data, visited=0 at address counter, then counter++.
  - After cell N*N-1 is accepted: load_ready=0 next cycle, go to SERVE, clear wall_hit.
  - load_start in LOAD is ignored.
- SERVE:
  - mem_ready=1.
  - maze_oe=1 at edge k: maze_in = wall bit of {row,col} from edge k+1 onward; maze_in holds its value until the next oe.
  - maze_we=1 at edge k: sets visited bit of {row,col}.
  - If that cell's wall bit is 1: visited is still set and wall_hit is set sticky.
  - oe and we in the same cycle to the same cell: read returns the wall bit (never changed by we).
  - solver_done=1 -> DUMP; mem_ready drops next cycle; oe/we in that cycle are still honoured.
- Outside SERVE: maze_oe/maze_we ignored; maze_in forced to 1 so a misbehaving solver sees walls everywhere.
- DUMP:
  - Dump counter starts at 0; synchronous read of the cell, registered outputs.
  - out_valid rises 2 cycles after DUMP entry, with out_row/out_col = counter and out_visited = stored bit.
  - Transfer happens on out_valid&&out_ready. Then out_valid=0 for 1 cycle while the next cell is read, so throughput is 1 cell per 2 cycles minimum.
  - out_* stable while out_valid=1 and out_ready=0.
  - After cell N*N-1 is transferred -> DONE.
- Index wrap: counters are 2*maze_width bits; terminal value is all ones, and no wrap past it occurs.
- Reset mid-operation (any state): immediate return to IDLE; a partial load or dump is abandoned and memory is left as is.

Optional Feature:
- Macro: VISIT_COUNT_EN
- With the macro defined:
  - Adds output visit_count [2*maze_width:0].
  - Cleared on entry to SERVE.
  - Increments on a maze_we whose target visited bit was 0, so re-marks are not counted.
  - Requires a read-before-write of the visited bit in the same cycle (dual-port or internal bypass).
  - Holds its value through DUMP/DONE; reset value 0.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Load all-zero bitmap (4096 beats, load_valid held 1) -> load_ready high exactly 4096 cycles, mem_ready=1 one cycle after last beat, wall_hit=0.
- Load wall at {row=5,col=9} only; oe with row=5,col=9 -> maze_in=1 next cycle; oe with row=5,col=10 -> maze_in=0; oe in IDLE -> maze_in=1.
- SERVE: we at {0,0},{0,1},{0,1}; solver_done=1; dump with out_ready=1 -> 4096 transfers, out_visited=1 only for cells 0 and 1; dump_done=1 after last; (VISIT_COUNT_EN) visit_count=2.
- we at wall cell {5,9} -> wall_hit=1 and stays 1 through DUMP; next load completes -> wall_hit=0.
- Dump with out_ready toggling 0/1 every 3 cycles -> out_row/out_col/out_visited unchanged while stalled, no cell skipped or repeated.
- Assert rst_n=0 during LOAD at beat 100 -> all outputs at reset values immediately (maze_in=1); load_start restarts load at address 0.

Source files
------------

// File: rtl/maze_mem.sv
`timescale 1ns/1ps
// maze_mem: cell store for the maze solver.
// Loads an N x N wall bitmap over a valid/ready stream, serves solver reads
// (maze_oe) and visited marks (maze_we), then streams the visited map out.
// Optional feature macro: VISIT_COUNT_EN adds the visit_count output, which
// counts first-time marks during a solve.
module maze_mem #(
  parameter int maze_width = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_data,
  output logic                  load_ready,
  output logic                  mem_ready,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  solver_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [maze_width-1:0] out_row,
  output logic [maze_width-1:0] out_col,
  output logic                  out_visited,
  output logic                  dump_done,
  output logic                  wall_hit
`ifdef VISIT_COUNT_EN
  ,
  output logic [2*maze_width:0] visit_count
`endif
);

  localparam int AW    = 2 * maze_width;
  localparam int Cells = 1 << AW;
  localparam logic [AW-1:0] CntOne = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SERVE,
    DUMP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          maze_in_q, maze_in_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_visited_q, out_visited_d;
  logic          wall_hit_q, wall_hit_d;

`ifdef VISIT_COUNT_EN
  localparam logic [AW:0] VisOne = {{AW{1'b0}}, 1'b1};
  logic [AW:0] visit_cnt_q, visit_cnt_d;
`endif

  logic wall_mem [Cells];
  logic vis_mem  [Cells];

  logic [AW-1:0] solver_addr;
  logic          serving;
  logic          load_fire;
  logic          mark_fire;
  logic          cnt_last;

  assign solver_addr = {row, col};
  assign serving     = (state_q == SERVE);
  assign load_fire   = (state_q == LOAD) && load_valid;
  assign mark_fire   = serving && maze_we;
  assign cnt_last    = &cnt_q;

  // Cell storage: loads write both bits, solver marks only set the visited bit.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      wall_mem[cnt_q] <= load_data;
      vis_mem[cnt_q]  <= 1'b0;
    end else if (mark_fire) begin
      vis_mem[solver_addr] <= 1'b1;
    end
  end

  // Next-state and datapath decode for the load / serve / dump sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    maze_in_d     = maze_in_q;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_visited_d = out_visited_q;
    wall_hit_d    = wall_hit_q;
`ifdef VISIT_COUNT_EN
    visit_cnt_d   = visit_cnt_q;
    if (mark_fire && !vis_mem[solver_addr]) begin
      visit_cnt_d = visit_cnt_q + VisOne;
    end
`endif

    if (mark_fire && wall_mem[solver_addr]) begin
      wall_hit_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        if (load_valid) begin
          if (cnt_last) begin
            state_d    = SERVE;
            cnt_d      = '0;
            wall_hit_d = 1'b0;
            maze_in_d  = 1'b1;
`ifdef VISIT_COUNT_EN
            visit_cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      SERVE: begin
        if (maze_oe) begin
          maze_in_d = wall_mem[solver_addr];
        end
        if (solver_done) begin
          state_d = DUMP;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      DUMP: begin
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (cnt_last) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end else if (armed_q) begin
          out_valid_d   = 1'b1;
          out_addr_d    = cnt_q;
          out_visited_d = vis_mem[cnt_q];
        end else begin
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers, all returned to idle values by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      maze_in_q     <= 1'b1;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_visited_q <= 1'b0;
      wall_hit_q    <= 1'b0;
`ifdef VISIT_COUNT_EN
      visit_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      maze_in_q     <= maze_in_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_visited_q <= out_visited_d;
      wall_hit_q    <= wall_hit_d;
`ifdef VISIT_COUNT_EN
      visit_cnt_q   <= visit_cnt_d;
`endif
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign mem_ready   = serving;
  assign maze_in     = serving ? maze_in_q : 1'b1;
  assign out_valid   = out_valid_q;
  assign out_row     = out_addr_q[AW-1:maze_width];
  assign out_col     = out_addr_q[maze_width-1:0];
  assign out_visited = out_visited_q;
  assign dump_done   = (state_q == DONE);
  assign wall_hit    = wall_hit_q;
`ifdef VISIT_COUNT_EN
  assign visit_count = visit_cnt_q;
`endif

endmodule

// File: tb/tb_maze_mem.sv
`timescale 1ns/1ps
// tb_maze_mem: randomized scenarios against a cell-level model of the maze store.
module tb_maze_mem;

  localparam int W     = 6;
  localparam int N     = 1 << W;
  localparam int Cells = N * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic load_valid = 1'b0;
  logic load_data = 1'b0;
  logic maze_oe = 1'b0;
  logic maze_we = 1'b0;
  logic solver_done = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] row = '0;
  logic [W-1:0] col = '0;

  logic load_ready, mem_ready, maze_in, out_valid, out_visited, dump_done, wall_hit;
  logic [W-1:0] out_row, out_col;
`ifdef VISIT_COUNT_EN
  logic [2*W:0] visit_count;
`endif

  int checks = 0;
  int failures = 0;

  bit wallModel [Cells];
  bit visModel  [Cells];
  bit wallHitModel = 1'b0;
  int visitModel = 0;

  always #5 clk = ~clk;

  maze_mem #(.maze_width(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .mem_ready(mem_ready),
    .row(row),
    .col(col),
    .maze_oe(maze_oe),
    .maze_we(maze_we),
    .maze_in(maze_in),
    .solver_done(solver_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_col(out_col),
    .out_visited(out_visited),
    .dump_done(dump_done),
    .wall_hit(wall_hit)
`ifdef VISIT_COUNT_EN
    ,
    .visit_count(visit_count)
`endif
  );

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bitmap(input int mode);
    for (int i = 0; i < Cells; i++) begin
      wallModel[i] = (mode == 1) && ($urandom_range(0, 3) == 0);
    end
    if (mode == 1) begin
      wallModel[5*N+9]  = 1'b1;
      wallModel[5*N+10] = 1'b0;
    end
  endtask

  task automatic model_mark(input int a);
    if (wallModel[a]) wallHitModel = 1'b1;
    if (!visModel[a]) visitModel++;
    visModel[a] = 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    rst_n = 1'b0;
    repeat (3) tick();
    got = {load_ready, mem_ready, maze_in, out_valid, dump_done, wall_hit, out_visited, out_row, out_col};
    checks++;
    if (got !== {7'b0010000, 12'b0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", got, {7'b0010000, 12'b0});
    end
`ifdef VISIT_COUNT_EN
    checks++;
    if (visit_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_visit_count: got %0d expected 0", visit_count);
    end
`endif
    rst_n = 1'b1;
    tick();
    maze_oe = 1'b1; row = 6'd5; col = 6'd10;
    tick();
    maze_oe = 1'b0;
    checks++;
    if ({maze_in, load_ready, mem_ready} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL idle_oe: got {maze_in,load_ready,mem_ready}=%b expected 100", {maze_in, load_ready, mem_ready});
    end
  endtask

  task automatic test_load(input bit gaps);
    int idx, cyc, readyCycles, memBad, hitBad;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if ({load_ready, dump_done} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL load_entry: got {load_ready,dump_done}=%b expected 10", {load_ready, dump_done});
    end
    idx = 0; cyc = 0; readyCycles = 0; memBad = 0; hitBad = 0;
    while (idx < Cells && cyc < 4*Cells) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_data  = wallModel[idx];
      if (load_ready) readyCycles++;
      if (mem_ready) memBad++;
      if (wall_hit !== wallHitModel) hitBad++;
      if (load_valid && load_ready) idx++;
      cyc++;
      tick();
    end
    load_valid = 1'b0;
    load_data  = 1'b0;
    checks++;
    if (idx !== Cells) begin
      failures++;
      $display("[TB] FAIL load_beats: got %0d beats expected %0d", idx, Cells);
    end
    checks++;
    if (readyCycles !== cyc) begin
      failures++;
      $display("[TB] FAIL load_ready_cycles: got %0d expected %0d", readyCycles, cyc);
    end
    if (!gaps) begin
      checks++;
      if (cyc !== Cells) begin
        failures++;
        $display("[TB] FAIL load_duration: got %0d cycles expected %0d", cyc, Cells);
      end
    end
    checks++;
    if (memBad !== 0 || hitBad !== 0) begin
      failures++;
      $display("[TB] FAIL load_side_outputs: got mem_ready errs %0d wall_hit errs %0d expected 0 0", memBad, hitBad);
    end
    checks++;
    if ({mem_ready, load_ready, wall_hit} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL load_complete: got {mem_ready,load_ready,wall_hit}=%b expected 100", {mem_ready, load_ready, wall_hit});
    end
    wallHitModel = 1'b0;
    visitModel = 0;
    for (int i = 0; i < Cells; i++) visModel[i] = 1'b0;
  endtask

  task automatic test_serve_basic();
    maze_oe = 1'b1; row = 6'd3; col = 6'd3;
    tick();
    maze_oe = 1'b0;
    checks++;
    if (maze_in !== wallModel[3*N+3]) begin
      failures++;
      $display("[TB] FAIL basic_read: got %b expected %b", maze_in, wallModel[3*N+3]);
    end
    maze_we = 1'b1; row = 6'd0; col = 6'd0;
    tick(); model_mark(0);
    col = 6'd1;
    tick(); model_mark(1);
    maze_oe = 1'b1; solver_done = 1'b1;
    tick(); model_mark(1);
    maze_oe = 1'b0; maze_we = 1'b0; solver_done = 1'b0;
    checks++;
    if ({mem_ready, maze_in, wall_hit} !== {1'b0, 1'b1, wallHitModel}) begin
      failures++;
      $display("[TB] FAIL basic_done: got {mem_ready,maze_in,wall_hit}=%b expected 01%b", {mem_ready, maze_in, wall_hit}, wallHitModel);
    end
  endtask

  task automatic test_serve_random();
    bit oe, we;
    int a;
    logic expIn;
    expIn = 1'b1;
    for (int k = 0; k < 80; k++) begin
      oe = (k < 2 || k == 4) ? 1'b1 : 1'($urandom_range(0, 1));
      we = (k == 3 || k == 4) ? 1'b1 : ($urandom_range(0, 3) == 0);
      if (k == 0 || k == 3 || k == 4) begin row = 6'd5; col = 6'd9; end
      else if (k == 1) begin row = 6'd5; col = 6'd10; end
      else begin row = W'($urandom_range(0, N-1)); col = W'($urandom_range(0, N-1)); end
      maze_oe = oe; maze_we = we;
      a = int'(row) * N + int'(col);
      tick();
      if (oe) expIn = wallModel[a];
      if (we) model_mark(a);
      checks++;
      if ({maze_in, wall_hit, mem_ready} !== {expIn, wallHitModel, 1'b1}) begin
        failures++;
        $display("[TB] FAIL serve_step%0d: got {maze_in,wall_hit,mem_ready}=%b expected %b%b1", k, {maze_in, wall_hit, mem_ready}, expIn, wallHitModel);
      end
    end
    maze_oe = 1'b0;
    maze_we = 1'b1; row = W'($urandom_range(0, N-1)); col = 6'd20; solver_done = 1'b1;
    a = int'(row) * N + 20;
    tick();
    model_mark(a);
    maze_we = 1'b0; solver_done = 1'b0;
    checks++;
    if ({mem_ready, maze_in, wall_hit} !== {1'b0, 1'b1, wallHitModel}) begin
      failures++;
      $display("[TB] FAIL serve_done: got {mem_ready,maze_in,wall_hit}=%b expected 01%b", {mem_ready, maze_in, wall_hit}, wallHitModel);
    end
  endtask

  task automatic test_dump(input bit stall);
    int idx, cyc, firstValid, gapBad, doneEarly;
    logic prevValid, prevReady, prevVis;
    logic [W-1:0] prevRow, prevCol;
    logic [2*W-1:0] ea;
    idx = 0; cyc = 0; firstValid = -1; gapBad = 0; doneEarly = 0;
    prevValid = 1'b0; prevReady = 1'b0; prevVis = 1'b0; prevRow = '0; prevCol = '0;
    while (idx < Cells && cyc < 8*Cells) begin
      out_ready = stall ? (((cyc / 3) % 2) == 0) : 1'b1;
      if (out_valid && firstValid < 0) firstValid = cyc;
      if (dump_done) doneEarly++;
      if (prevValid && prevReady && out_valid) gapBad++;
      if (prevValid && !prevReady) begin
        checks++;
        if ({out_valid, out_row, out_col, out_visited} !== {1'b1, prevRow, prevCol, prevVis}) begin
          failures++;
          $display("[TB] FAIL dump_stall_hold: got %b expected %b", {out_valid, out_row, out_col, out_visited}, {1'b1, prevRow, prevCol, prevVis});
        end
      end
      if (out_valid) begin
        ea = idx[2*W-1:0];
        checks++;
        if ({out_row, out_col, out_visited} !== {ea, visModel[idx]}) begin
          failures++;
          $display("[TB] FAIL dump_cell%0d: got row %0d col %0d visited %b expected row %0d col %0d visited %b",
                   idx, out_row, out_col, out_visited, ea[2*W-1:W], ea[W-1:0], visModel[idx]);
        end
      end
      prevValid = out_valid; prevReady = out_ready;
      prevRow = out_row; prevCol = out_col; prevVis = out_visited;
      if (out_valid && out_ready) idx++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (idx !== Cells || firstValid !== 2) begin
      failures++;
      $display("[TB] FAIL dump_progress: got %0d cells first valid at %0d expected %0d cells at 2", idx, firstValid, Cells);
    end
    if (!stall) begin
      checks++;
      if (cyc !== 2*Cells + 1) begin
        failures++;
        $display("[TB] FAIL dump_throughput: got %0d cycles expected %0d", cyc, 2*Cells + 1);
      end
    end
    checks++;
    if (gapBad !== 0 || doneEarly !== 0) begin
      failures++;
      $display("[TB] FAIL dump_gaps: got %0d missing gaps %0d early done expected 0 0", gapBad, doneEarly);
    end
    checks++;
    if ({dump_done, out_valid, maze_in, wall_hit} !== {3'b101, wallHitModel}) begin
      failures++;
      $display("[TB] FAIL dump_end: got {dump_done,out_valid,maze_in,wall_hit}=%b expected 101%b", {dump_done, out_valid, maze_in, wall_hit}, wallHitModel);
    end
`ifdef VISIT_COUNT_EN
    checks++;
    if (visit_count !== (2*W+1)'(visitModel)) begin
      failures++;
      $display("[TB] FAIL visit_count: got %0d expected %0d", visit_count, visitModel);
    end
`endif
  endtask

  task automatic test_done_state();
    maze_oe = 1'b1; maze_we = 1'b1; row = 6'd5; col = 6'd10;
    tick();
    maze_oe = 1'b0; maze_we = 1'b0;
    checks++;
    if ({maze_in, dump_done, wall_hit, mem_ready} !== {2'b11, wallHitModel, 1'b0}) begin
      failures++;
      $display("[TB] FAIL done_state: got {maze_in,dump_done,wall_hit,mem_ready}=%b expected 11%b0", {maze_in, dump_done, wall_hit, mem_ready}, wallHitModel);
    end
  endtask

  task automatic test_reset_midload();
    logic [18:0] got;
    int a;
    rst_n = 1'b0;
    #2;
    got = {load_ready, mem_ready, maze_in, out_valid, dump_done, wall_hit, out_visited, out_row, out_col};
    checks++;
    if (got !== {7'b0010000, 12'b0}) begin
      failures++;
      $display("[TB] FAIL reset_from_serve: got %b expected %b", got, {7'b0010000, 12'b0});
    end
    tick();
    rst_n = 1'b1;
    tick();
    fill_bitmap(1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b1;
      load_data  = ~wallModel[i];
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    got = {load_ready, mem_ready, maze_in, out_valid, dump_done, wall_hit, out_visited, out_row, out_col};
    checks++;
    if (got !== {7'b0010000, 12'b0}) begin
      failures++;
      $display("[TB] FAIL reset_mid_load: got %b expected %b", got, {7'b0010000, 12'b0});
    end
`ifdef VISIT_COUNT_EN
    checks++;
    if (visit_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_load_visit_count: got %0d expected 0", visit_count);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    wallHitModel = 1'b0;
    test_load(1'b1);
    for (int k = 0; k < 16; k++) begin
      a = (k < 4) ? k : int'($urandom_range(0, Cells-1));
      row = W'(a / N); col = W'(a % N); maze_oe = 1'b1;
      tick();
      maze_oe = 1'b0;
      checks++;
      if (maze_in !== wallModel[a]) begin
        failures++;
        $display("[TB] FAIL reload_read%0d: cell %0d got %b expected %b", k, a, maze_in, wallModel[a]);
      end
    end
  endtask

  initial begin
    $display("[TB] starting maze_mem bench");
    test_reset();
    fill_bitmap(0);
    test_load(1'b0);
    test_serve_basic();
    test_dump(1'b0);
    fill_bitmap(1);
    test_load(1'b1);
    test_serve_random();
    test_dump(1'b1);
    test_done_state();
    fill_bitmap(1);
    test_load(1'b0);
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
